// File: rtl/spi_flash_pkg.sv
// Opcode constants and FSM state encoding for the SPI flash responder and controller.
package spi_flash_pkg;

    localparam logic [7:0] READ      = 8'h03;
    localparam logic [7:0] FAST_READ = 8'h0B;
    localparam logic [7:0] RDID      = 8'h9F;
    localparam logic [7:0] RDSR      = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_ID,
        ST_STAT,
        ST_IGNORE
    } flash_state_t;

    // Byte idx of the JEDEC ID, most significant first; 0xFF once past the end.
    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd0:    id_byte = id[23:16];
            2'd1:    id_byte = id[15:8];
            2'd2:    id_byte = id[7:0];
            default: id_byte = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Synchronizes SCK, CS and MOSI into the clk domain and produces single-clk edge pulses.
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic cs_n,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic cs_s,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sck_pipe;
    logic [SYNC_STAGES-1:0] cs_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   sck_s;
    logic                   sck_q;
    logic                   cs_q;

    // CS resets to its idle-high level so leaving reset never looks like a CS fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_pipe  <= '0;
            cs_pipe   <= '1;
            mosi_pipe <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], sck};
            cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], cs_n};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
            sck_q     <= sck_s;
            cs_q      <= cs_s;
        end
    end

    assign sck_s    = sck_pipe[SYNC_STAGES-1];
    assign cs_s     = cs_pipe[SYNC_STAGES-1];
    assign mosi_s   = mosi_pipe[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign cs_fall  = ~cs_s & cs_q;
    assign cs_rise  = cs_s & ~cs_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 read-only flash emulator answering READ, FAST_READ, RDID and RDSR from a byte memory.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_BITS   = 12,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_spi_clk,
    input  logic                 i_spi_cs,
    input  logic                 i_spi_mosi,
    output logic                 o_spi_miso,
    output logic                 o_miso_oe,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic                 o_mem_rd,
    input  logic [7:0]           i_mem_data,
    output logic                 o_busy
);

    logic         sck_rise, sck_fall, cs_fall, cs_rise, cs_s, mosi_s;
    flash_state_t state, state_next;
    logic [2:0]   bit_cnt;
    logic [1:0]   byte_cnt;
    logic [7:0]   rx_sr;
    logic [7:0]   tx_sr;
    logic [23:0]  addr_sr;
    logic         is_fast;
    logic         load_pending;
    logic [7:0]   opcode_next;
    logic [23:0]  addr_next;
    logic         byte_done;
    logic         unused_bits;

    spi_input_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .sck      (i_spi_clk),
        .cs_n     (i_spi_cs),
        .mosi     (i_spi_mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .cs_s     (cs_s),
        .mosi_s   (mosi_s)
    );

    // Decode sees the byte including the bit arriving on this very rise.
    assign opcode_next = {rx_sr[6:0], mosi_s};
    assign addr_next   = {addr_sr[22:0], mosi_s};
    assign byte_done   = (bit_cnt == 3'd7);
    assign o_busy      = ~cs_s;
    assign unused_bits = ^{rx_sr[7], addr_sr[23], addr_next[23:ADDR_BITS]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // CS rise outranks every SCK edge; a CS fall outside IDLE restarts the frame.
    always_comb begin
        state_next = state;
        if (cs_rise) begin
            state_next = ST_IDLE;
        end else if (cs_fall) begin
            state_next = ST_CMD;
        end else begin
            case (state)
                ST_CMD: begin
                    if (sck_rise && byte_done) begin
                        case (opcode_next)
                            READ, FAST_READ: state_next = ST_ADDR;
                            RDID:            state_next = ST_ID;
                            RDSR:            state_next = ST_STAT;
                            default:         state_next = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (sck_rise && byte_done && byte_cnt == 2'd2)
                        state_next = is_fast ? ST_DUMMY : ST_DATA;
                end
                ST_DUMMY: begin
                    if (sck_rise && byte_done) state_next = ST_DATA;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_miso_oe = 1'b0;
        case (state)
            ST_DUMMY, ST_DATA, ST_ID, ST_STAT: o_miso_oe = 1'b1;
            default: ;
        endcase
    end

    // Every read strobe is followed two clks later by a load of the TX register,
    // which lands well before the next SCK fall given the minimum SCK period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            addr_sr      <= '0;
            is_fast      <= 1'b0;
            load_pending <= 1'b0;
            o_spi_miso   <= 1'b0;
            o_mem_rd     <= 1'b0;
            o_mem_addr   <= '0;
        end else begin
            o_mem_rd     <= 1'b0;
            load_pending <= o_mem_rd;
            if (cs_rise || cs_fall) begin
                bit_cnt      <= '0;
                byte_cnt     <= '0;
                o_spi_miso   <= 1'b0;
                load_pending <= 1'b0;
            end else begin
                if (load_pending) tx_sr <= i_mem_data;
                case (state)
                    ST_CMD: begin
                        if (sck_rise) begin
                            rx_sr   <= opcode_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (byte_done) begin
                                is_fast  <= (opcode_next == FAST_READ);
                                byte_cnt <= '0;
                                tx_sr    <= (opcode_next == RDID) ? JEDEC_ID[23:16] : 8'h00;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            addr_sr <= addr_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (byte_done) begin
                                if (byte_cnt == 2'd2) begin
                                    byte_cnt   <= '0;
                                    o_mem_addr <= addr_next[ADDR_BITS-1:0];
                                    o_mem_rd   <= 1'b1;
                                end else begin
                                    byte_cnt <= byte_cnt + 2'd1;
                                end
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (sck_rise) bit_cnt <= bit_cnt + 3'd1;
                        if (sck_fall) o_spi_miso <= 1'b0;
                    end
                    ST_DATA: begin
                        if (sck_fall) begin
                            o_spi_miso <= tx_sr[7];
                            tx_sr      <= {tx_sr[6:0], 1'b0};
                            bit_cnt    <= bit_cnt + 3'd1;
                            if (byte_done) begin
                                o_mem_addr <= o_mem_addr + ADDR_BITS'(1);
                                o_mem_rd   <= 1'b1;
                            end
                        end
                    end
                    ST_ID: begin
                        if (sck_fall) begin
                            o_spi_miso <= tx_sr[7];
                            bit_cnt    <= bit_cnt + 3'd1;
                            if (byte_done) begin
                                tx_sr <= id_byte(JEDEC_ID, (byte_cnt == 2'd3) ? 2'd3 : byte_cnt + 2'd1);
                                if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
                            end else begin
                                tx_sr <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end
                    ST_STAT: begin
                        if (sck_fall) o_spi_miso <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench for spi_flash_responder: an SPI initiator plus a byte-level flash model.
module tb_spi_flash_responder;
    import spi_flash_pkg::*;

    localparam int          HALF     = 5;
    localparam int          MEM_SIZE = 4096;
    localparam logic [23:0] JEDEC    = 24'hEF4016;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        spi_clk  = 1'b0;
    logic        spi_cs   = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, miso_oe, mem_rd, busy;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic [7:0]  mem [MEM_SIZE];
    int          rd_count = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    spi_flash_responder #(
        .ADDR_BITS   (12),
        .JEDEC_ID    (JEDEC),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_spi_clk  (spi_clk),
        .i_spi_cs   (spi_cs),
        .i_spi_mosi (spi_mosi),
        .o_spi_miso (spi_miso),
        .o_miso_oe  (miso_oe),
        .o_mem_addr (mem_addr),
        .o_mem_rd   (mem_rd),
        .i_mem_data (mem_data),
        .o_busy     (busy)
    );

    // ROM image with one-clk read latency, plus a tally of read strobes.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_data <= mem[mem_addr];
            rd_count <= rd_count + 1;
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Shifts out the top nBits of tx MSB first, sampling MISO/oe just before each SCK rise.
    task automatic applyStimulus(input logic [7:0] tx, input int nBits, output logic [7:0] rx,
                                 output logic oe_all, output logic oe_any);
        rx     = 8'h00;
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = 7; i > 7 - nBits; i--) begin
            spi_mosi = tx[i];
            waitClk(HALF);
            rx      = {rx[6:0], spi_miso};
            oe_all &= miso_oe;
            oe_any |= miso_oe;
            spi_clk = 1'b1;
            waitClk(HALF);
            spi_clk = 1'b0;
        end
    endtask

    function automatic bit isKnownOp(input logic [7:0] op);
        return (op == READ) || (op == FAST_READ) || (op == RDID) || (op == RDSR);
    endfunction

    // Expected idx-th byte after the command header (the FAST_READ dummy counts as byte 0).
    function automatic logic [7:0] modelByte(input logic [7:0] op, input logic [23:0] addr, input int idx);
        int base;
        base = int'(addr) % MEM_SIZE;
        if (op == READ)      return mem[(base + idx) % MEM_SIZE];
        if (op == FAST_READ) return (idx == 0) ? 8'h00 : mem[(base + idx - 1) % MEM_SIZE];
        if (op == RDID)      return (idx < 3) ? JEDEC[8*(2-idx) +: 8] : 8'hFF;
        return 8'h00;
    endfunction

    // One memory fetch at the end of the address, then one per completed data byte.
    function automatic int modelReads(input logic [7:0] op, input int n_resp);
        if (op == READ)      return n_resp + 1;
        if (op == FAST_READ) return (n_resp > 0) ? n_resp : 1;
        return 0;
    endfunction

    task automatic runFrame(input logic [7:0] op, input logic [23:0] addr, input int n_resp, input string tag);
        logic [7:0] rx;
        logic       oe_all, oe_any, hdr_oe, resp_oe_all, resp_oe_any;
        int         rd_before;
        rd_before   = rd_count;
        hdr_oe      = 1'b0;
        resp_oe_all = 1'b1;
        resp_oe_any = 1'b0;
        spi_cs = 1'b0;
        waitClk(HALF);
        applyStimulus(op, 8, rx, oe_all, oe_any);
        hdr_oe |= oe_any;
        checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        if (op == READ || op == FAST_READ) begin
            for (int b = 2; b >= 0; b--) begin
                applyStimulus(addr[8*b +: 8], 8, rx, oe_all, oe_any);
                hdr_oe |= oe_any;
            end
        end
        checkOutput({tag, " header oe"}, 32'(hdr_oe), 32'd0);
        for (int i = 0; i < n_resp; i++) begin
            applyStimulus(8'($urandom), 8, rx, oe_all, oe_any);
            resp_oe_all &= oe_all;
            resp_oe_any |= oe_any;
            if (isKnownOp(op))
                checkOutput($sformatf("%s byte%0d", tag, i), 32'(rx), 32'(modelByte(op, addr, i)));
        end
        if (n_resp > 0) begin
            if (isKnownOp(op)) checkOutput({tag, " response oe"}, 32'(resp_oe_all), 32'd1);
            else               checkOutput({tag, " ignored oe"}, 32'(resp_oe_any), 32'd0);
        end
        waitClk(HALF);
        spi_cs = 1'b1;
        waitClk(8);
        checkOutput({tag, " idle oe"}, 32'(miso_oe), 32'd0);
        checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " reads"}, 32'(rd_count - rd_before), 32'(modelReads(op, n_resp)));
    endtask

    initial begin
        logic [7:0]  rx, op, first_byte;
        logic        oe_all, oe_any;
        logic [23:0] addr;
        int          rd_before, n_resp;

        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
        mem[12'h010] = 8'hA5;
        mem[12'h011] = 8'h5A;

        waitClk(4);
        reset = 1'b0;
        waitClk(3);
        checkOutput("reset miso", 32'(spi_miso), 32'd0);
        checkOutput("reset oe", 32'(miso_oe), 32'd0);
        checkOutput("reset mem_rd", 32'(mem_rd), 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);

        runFrame(READ, 24'h000010, 2, "read 010");
        runFrame(READ, 24'h000FFF, 2, "read wrap");
        runFrame(READ, 24'h123456, 1, "read masked");
        runFrame(FAST_READ, 24'h000010, 2, "fast read");
        runFrame(RDID, 24'h000000, 4, "rdid");
        runFrame(RDSR, 24'h000000, 2, "rdsr");
        runFrame(8'h02, 24'h000000, 3, "write op");

        rd_before = rd_count;
        spi_cs = 1'b0;
        waitClk(HALF);
        applyStimulus(READ, 8, rx, oe_all, oe_any);
        applyStimulus(8'h00, 8, rx, oe_all, oe_any);
        applyStimulus(8'h00, 4, rx, oe_all, oe_any);
        waitClk(HALF);
        spi_cs = 1'b1;
        waitClk(8);
        checkOutput("abort oe", 32'(miso_oe), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort reads", 32'(rd_count - rd_before), 32'd0);
        runFrame(READ, 24'h000010, 2, "read after abort");

        spi_cs = 1'b0;
        waitClk(HALF);
        applyStimulus(READ, 8, rx, oe_all, oe_any);
        applyStimulus(8'h00, 8, rx, oe_all, oe_any);
        applyStimulus(8'h00, 8, rx, oe_all, oe_any);
        applyStimulus(8'h10, 8, rx, oe_all, oe_any);
        applyStimulus(8'h00, 3, rx, oe_all, oe_any);
        first_byte = mem[12'h010];
        checkOutput("partial data bits", 32'(rx[2:0]), 32'(first_byte[7:5]));
        reset = 1'b1;
        #1;
        checkOutput("midreset miso", 32'(spi_miso), 32'd0);
        checkOutput("midreset oe", 32'(miso_oe), 32'd0);
        checkOutput("midreset mem_rd", 32'(mem_rd), 32'd0);
        checkOutput("midreset mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        spi_cs = 1'b1;
        waitClk(3);
        reset = 1'b0;
        waitClk(4);
        runFrame(READ, 24'h000010, 2, "read after reset");

        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 5))
                0:       op = READ;
                1:       op = FAST_READ;
                2:       op = RDID;
                3:       op = RDSR;
                4:       op = 8'h20;
                default: op = 8'($urandom);
            endcase
            addr   = 24'($urandom);
            n_resp = $urandom_range(1, 4);
            runFrame(op, addr, n_resp, $sformatf("rand%0d op%02h", t, op));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
